// File: rtl/gcd_pkg.sv
// Shared constants and controller-command decode for the GCD unit.
package gcd_pkg;

   localparam int GCD_WIDTH = 8;
   localparam int GCD_CNT_W = 8;

   typedef enum logic [2:0] {
      NONE,
      LOAD,
      SUBA,
      SUBB,
      CAPTURE
   } gcd_cmd_t;

   // Primary command class of one cycle's command lines. A full load needs both
   // latches with both selects low. A subtract needs a latch with its select high.
   function automatic gcd_cmd_t gcd_decode(input logic al, input logic bl,
                                           input logic a_sel, input logic b_sel,
                                           input logic res_l);
      if (al && bl && !a_sel && !b_sel) return LOAD;
      if (al && a_sel)                  return SUBA;
      if (bl && b_sel)                  return SUBB;
      if (res_l)                        return CAPTURE;
      return NONE;
   endfunction

endpackage

// File: rtl/gcd_operand_buffer.sv
// One-entry holding register for operand pairs, emptied by the datapath's load.
module gcd_operand_buffer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             pop,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_a,
   output logic [WIDTH-1:0] out_b
);

   // Valid/ready: a transfer happens on any rising edge where valid and ready
   // are both high. A producer holds valid and data steady until that edge.
   assign in_ready = !out_valid && !rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_a     <= '0;
         out_b     <= '0;
      end else if (in_valid && in_ready) begin
         out_valid <= 1'b1;
         out_a     <= in_a;
         out_b     <= in_b;
      end else if (pop) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/gcd_datapath.sv
// GCD datapath: operand registers, subtract/compare, iteration counter and
// result register driven by the gcd_controller command lines.
module gcd_datapath
   import gcd_pkg::*;
#(
   parameter int WIDTH = GCD_WIDTH,
   parameter int CNT_W = GCD_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             start,
   input  logic             A_sel,
   input  logic             B_sel,
   input  logic             AL,
   input  logic             BL,
   input  logic             res_L,
   output logic             equal_val,
   output logic             less_val,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic [CNT_W-1:0] res_iters
);

   logic             buf_valid;
   logic [WIDTH-1:0] buf_a;
   logic [WIDTH-1:0] buf_b;
   logic [WIDTH-1:0] reg_a;
   logic [WIDTH-1:0] reg_b;
   logic [WIDTH-1:0] load_a;
   logic [WIDTH-1:0] load_b;
   logic [CNT_W-1:0] iter_cnt;
   logic             busy;
   gcd_cmd_t         cmd;
   logic             do_load;
   logic             sub_a;
   logic             sub_b;
   logic             do_cap;

   gcd_operand_buffer #(.WIDTH(WIDTH)) u_buf (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (op_valid),
      .in_ready  (op_ready),
      .in_a      (op_a),
      .in_b      (op_b),
      .pop       (do_load),
      .out_valid (buf_valid),
      .out_a     (buf_a),
      .out_b     (buf_b)
   );

   assign cmd     = gcd_decode(AL, BL, A_sel, B_sel, res_L);
   assign do_load = (cmd == LOAD);
   assign sub_a   = AL && A_sel;
   assign sub_b   = BL && B_sel;
   assign do_cap  = res_L && busy && !res_valid;

   // gcd(x,0) = x: a zero operand loads the other value into both registers so
   // the controller sees equality immediately instead of looping forever.
   always_comb begin
      load_a = buf_a;
      load_b = buf_b;
      if (buf_a == '0) begin
         load_a = buf_b;
         load_b = buf_b;
      end else if (buf_b == '0) begin
         load_a = buf_a;
         load_b = buf_a;
      end
   end

   assign equal_val = (reg_a == reg_b);
   assign less_val  = (reg_a < reg_b);
   assign start     = buf_valid && !busy && !res_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         reg_a    <= '0;
         reg_b    <= '0;
         iter_cnt <= '0;
      end else if (do_load) begin
         reg_a    <= load_a;
         reg_b    <= load_b;
         iter_cnt <= '0;
      end else begin
         // Both differences use pre-edge values, so a combined command is safe.
         if (sub_a) reg_a <= reg_a - reg_b;
         if (sub_b) reg_b <= reg_b - reg_a;
         if ((sub_a || sub_b) && (iter_cnt != '1)) iter_cnt <= iter_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy      <= 1'b0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_iters <= '0;
      end else begin
         if (do_cap) begin
            busy      <= 1'b0;
            res_valid <= 1'b1;
            res_data  <= reg_a;
            res_iters <= iter_cnt;
         end else if (res_ready) begin
            res_valid <= 1'b0;
         end
         if (do_load) busy <= 1'b1;
      end
   end

endmodule

// File: tb/tb_gcd_datapath.sv
// Bench for gcd_datapath: behavioural controller, scoreboard with reference GCD
// model, directed scenarios plus random operand pairs.
module tb_gcd_datapath;
   import gcd_pkg::GCD_WIDTH;
   import gcd_pkg::GCD_CNT_W;

   localparam int W  = GCD_WIDTH;
   localparam int CW = GCD_CNT_W;
   localparam int RW = W + CW;

   logic          clk = 1'b0;
   logic          rst;
   logic          op_valid;
   logic          op_ready;
   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic          start;
   logic          A_sel, B_sel, AL, BL, res_L;
   logic          equal_val, less_val;
   logic          res_valid;
   logic          res_ready;
   logic [W-1:0]  res_data;
   logic [CW-1:0] res_iters;

   logic ctrl_en, rand_ready, rr_fixed, rr_rand;
   logic c_al, c_bl, c_as, c_bs, c_rl, c_less;
   logic d_al, d_bl, d_as, d_bs, d_rl;

   logic [RW-1:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   gcd_datapath dut (
      .clk       (clk),
      .rst       (rst),
      .op_valid  (op_valid),
      .op_ready  (op_ready),
      .op_a      (op_a),
      .op_b      (op_b),
      .start     (start),
      .A_sel     (A_sel),
      .B_sel     (B_sel),
      .AL        (AL),
      .BL        (BL),
      .res_L     (res_L),
      .equal_val (equal_val),
      .less_val  (less_val),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_iters (res_iters)
   );

   // clock / reset
   always #5 clk = ~clk;

   assign AL        = ctrl_en ? c_al : d_al;
   assign BL        = ctrl_en ? c_bl : d_bl;
   assign A_sel     = ctrl_en ? c_as : d_as;
   assign B_sel     = ctrl_en ? c_bs : d_bs;
   assign res_L     = ctrl_en ? c_rl : d_rl;
   assign res_ready = rand_ready ? rr_rand : rr_fixed;

   always @(posedge clk) begin
      #2 rr_rand = 1'($urandom_range(0, 1));
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: Euclid for the value, repeated subtraction for the step count.
   function automatic logic [RW-1:0] ref_result(input int a, input int b);
      int x, y, t, n, g;
      logic [W-1:0]  gw;
      logic [CW-1:0] nw;
      if (a == 0 || b == 0) begin
         gw = W'(a + b);
         return {gw, CW'(0)};
      end
      x = a; y = b;
      while (y != 0) begin
         t = x % y; x = y; y = t;
      end
      g = x;
      x = a; y = b; n = 0;
      while (x != y) begin
         if (x > y) x = x - y; else y = y - x;
         n++;
      end
      if (n > (1 << CW) - 1) n = (1 << CW) - 1;
      gw = W'(g);
      nw = CW'(n);
      return {gw, nw};
   endfunction

   // behavioural gcd_controller
   typedef enum {C_IDLE, C_EQ, C_CMP, C_SUB, C_DONE, C_CAP, C_HOLD} c_st_t;
   c_st_t c_st = C_IDLE;

   always @(negedge clk) begin
      c_al = 0; c_bl = 0; c_as = 0; c_bs = 0; c_rl = 0;
      if (rst || !ctrl_en) c_st = C_IDLE;
      else begin
         case (c_st)
            C_IDLE: if (start) begin c_al = 1; c_bl = 1; c_st = C_EQ; end
            C_EQ:   c_st = equal_val ? C_DONE : C_CMP;
            C_CMP:  begin c_less = less_val; c_st = C_SUB; end
            C_SUB:  begin
               if (c_less) begin c_bl = 1; c_bs = 1; end
               else begin c_al = 1; c_as = 1; end
               c_st = C_EQ;
            end
            C_DONE: c_st = C_CAP;
            C_CAP:  begin c_rl = 1; c_st = C_HOLD; end
            C_HOLD: if (res_valid) c_rl = 1; else c_st = C_IDLE;
            default: c_st = C_IDLE;
         endcase
      end
   end

   // scoreboard monitor
   logic [RW-1:0] held;
   logic [RW-1:0] exp_r;
   logic          hold_prev = 1'b0;

   always @(negedge clk) begin
      if (rst) hold_prev = 1'b0;
      else if (res_valid) begin
         if (hold_prev) check("res_stable", 32'({res_data, res_iters}), 32'(held));
         if (res_ready) begin
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_result: got %0d/%0d, expected none", res_data, res_iters);
            end else begin
               exp_r = exp_q.pop_front();
               check("res_data", 32'(res_data), 32'(exp_r[RW-1:CW]));
               check("res_iters", 32'(res_iters), 32'(exp_r[CW-1:0]));
            end
            hold_prev = 1'b0;
         end else begin
            hold_prev = 1'b1;
            held = {res_data, res_iters};
         end
      end else hold_prev = 1'b0;
   end

   // driver tasks
   task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit exp_en);
      int n = 0;
      op_a = a; op_b = b; op_valid = 1'b1;
      while (!op_ready && n < 3000) begin @(negedge clk); n++; end
      if (!op_ready) begin
         n_tests++; n_fail++;
         $display("FAIL op_accept_timeout: got op_ready=0, expected 1");
      end else begin
         if (exp_en) exp_q.push_back(ref_result(int'(a), int'(b)));
         @(negedge clk);
      end
      op_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
      if (exp_q.size() != 0) begin
         n_tests++; n_fail++;
         $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic cmd_cycle(input logic al, input logic bl, input logic as_, input logic bs, input logic rl);
      d_al = al; d_bl = bl; d_as = as_; d_bs = bs; d_rl = rl;
      @(negedge clk);
      d_al = 0; d_bl = 0; d_as = 0; d_bs = 0; d_rl = 0;
   endtask

   logic [W-1:0] ma, mb, na, nb;
   bit found;

   initial begin
      rst = 1; op_valid = 0; op_a = 0; op_b = 0;
      d_al = 0; d_bl = 0; d_as = 0; d_bs = 0; d_rl = 0;
      ctrl_en = 1; rand_ready = 0; rr_fixed = 1; rr_rand = 1;

      // reset state
      repeat (3) @(negedge clk);
      check("rst_op_ready", 32'(op_ready), 0);
      check("rst_res_valid", 32'(res_valid), 0);
      check("rst_res_data", 32'(res_data), 0);
      check("rst_res_iters", 32'(res_iters), 0);
      check("rst_start", 32'(start), 0);
      check("rst_equal", 32'(equal_val), 1);
      check("rst_less", 32'(less_val), 0);
      #1 rst = 0;
      #1 check("op_ready_after_rst", 32'(op_ready), 1);
      @(negedge clk);

      // normal job and zero guards
      send_op(8'd48, 8'd18, 1); drain();
      send_op(8'd0, 8'd15, 1);  drain();
      send_op(8'd0, 8'd0, 1);   drain();
      send_op(8'd27, 8'd0, 1);  drain();

      // backpressure
      rr_fixed = 0;
      send_op(8'd35, 8'd21, 1);
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (res_valid) found = 1;
      end
      check("bp_res_valid_rise", 32'(found), 1);
      repeat (5) begin
         @(negedge clk);
         check("bp_res_valid_hold", 32'(res_valid), 1);
      end
      @(posedge clk); #2 rr_fixed = 1;
      drain();

      // buffering during a running job
      send_op(8'd48, 8'd18, 1);
      send_op(8'd9, 8'd6, 1);
      check("buf_full_op_ready", 32'(op_ready), 0);
      check("buf_full_start", 32'(start), 0);
      send_op(8'd14, 8'd4, 1);
      drain();

      // reset in the middle of a job
      send_op(8'd100, 8'd75, 1);
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk); #1;
         if (c_as || c_bs) found = 1;
      end
      check("mid_rst_sub_seen", 32'(found), 1);
      rst = 1;
      @(negedge clk);
      check("mid_rst_res_valid", 32'(res_valid), 0);
      check("mid_rst_res_data", 32'(res_data), 0);
      check("mid_rst_res_iters", 32'(res_iters), 0);
      check("mid_rst_op_ready", 32'(op_ready), 0);
      check("mid_rst_start", 32'(start), 0);
      check("mid_rst_equal", 32'(equal_val), 1);
      check("mid_rst_less", 32'(less_val), 0);
      exp_q.delete();
      #1 rst = 0;
      repeat (3) @(negedge clk);
      check("post_rst_no_result", 32'(res_valid), 0);
      send_op(8'd100, 8'd75, 1); drain();

      // random pairs with random result backpressure
      rand_ready = 1;
      for (int i = 0; i < 16; i++) begin
         send_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), 1);
         if (i % 4 == 3) drain();
      end
      drain();
      rand_ready = 0;

      // direct command mode
      ctrl_en = 0;
      @(negedge clk);
      send_op(8'd10, 8'd4, 0);
      check("direct_start", 32'(start), 1);
      cmd_cycle(1, 0, 0, 0, 0);
      check("invalid_load_no_pop", 32'(op_ready), 0);
      check("invalid_load_regs", 32'(equal_val), 1);
      cmd_cycle(1, 1, 0, 0, 0);
      check("load_pop", 32'(op_ready), 1);
      check("load_equal", 32'(equal_val), 0);
      check("load_less", 32'(less_val), 0);
      ma = 8'd10; mb = 8'd4;
      na = ma - mb; nb = mb - ma; ma = na; mb = nb;
      cmd_cycle(1, 1, 1, 1, 0);
      check("simul_less", 32'(less_val), 32'(ma < mb));
      check("simul_equal", 32'(equal_val), 0);
      ma = ma - mb;
      cmd_cycle(1, 0, 1, 0, 0);
      exp_q.push_back({ma, CW'(2)});
      cmd_cycle(0, 0, 0, 0, 1);
      drain();

      // counter saturation
      send_op(8'd200, 8'd3, 0);
      cmd_cycle(1, 1, 0, 0, 0);
      for (int i = 0; i < 260; i++) cmd_cycle(1, 0, 1, 0, 0);
      ma = W'(200 - 260 * 3);
      exp_q.push_back({ma, CW'((1 << CW) - 1)});
      cmd_cycle(0, 0, 0, 0, 1);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
